// File: rtl/sys_defs.sv
// Shared definitions for the RV32M multiply path: widths, the multiply
// function encoding, and the operand extension helper.
package sys_defs;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int MULT_W     = 2 * XLEN;
  // Multiplier bits retired per cycle by the iterative core.
  localparam int MULT_DIGIT = 8;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_t;

  function automatic logic [MULT_W-1:0] extend(input logic [XLEN-1:0] v,
                                               input logic             sgn);
    return {{(MULT_W-XLEN){sgn & v[XLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/mult.sv
// Iterative 64x64 multiplier (low 64 product bits), one 8-bit digit per cycle.
// done stays high after an operation until the next start is sampled.
module mult
  import sys_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [MULT_W-1:0] mcand,
  input  logic [MULT_W-1:0] mplier,
  output logic [MULT_W-1:0] product,
  output logic              done
);

  localparam int STEPS = MULT_W / MULT_DIGIT;
  localparam int CNT_W = $clog2(STEPS);

  logic [MULT_W-1:0] acc;
  logic [MULT_W-1:0] mcand_sh;
  logic [MULT_W-1:0] mplier_sh;
  logic [MULT_W-1:0] partial;
  logic [CNT_W-1:0]  count;
  logic              running;

  assign partial = mcand_sh * {{(MULT_W-MULT_DIGIT){1'b0}}, mplier_sh[MULT_DIGIT-1:0]};
  assign product = acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      count     <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      acc       <= '0;
      mcand_sh  <= mcand;
      mplier_sh <= mplier;
      count     <= '0;
      running   <= 1'b1;
      done      <= 1'b0;
    end else if (running) begin
      // Shift-and-add over digits; only the low 64 bits are kept, which is
      // exact for sign-extended operands.
      acc       <= acc + partial;
      mcand_sh  <= mcand_sh << MULT_DIGIT;
      mplier_sh <= mplier_sh >> MULT_DIGIT;
      count     <= count + 1'b1;
      if (count == CNT_W'(STEPS-1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_fu.sv
// RV32M multiply functional unit: takes one op from the reservation station,
// runs it on the shared 64-bit mult core and offers the result on the CDB.
module mult_fu
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  issue_rs1,
  input  logic [XLEN-1:0]  issue_rs2,
  input  logic [1:0]       issue_func,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             squash,
  output logic             cdb_req,
  output logic [XLEN-1:0]  cdb_value,
  output logic [TAG_W-1:0] cdb_tag,
  input  logic             cdb_grant,
  output logic [1:0]       debug_state
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, WB} state_t;

  state_t            state, state_nxt;
  logic              fire;
  logic              complete;
  logic              take_result;
  logic              start_q;
  logic [MULT_W-1:0] mcand_q;
  logic [MULT_W-1:0] mplier_q;
  logic [MULT_W-1:0] product;
  logic              mult_done;
  mult_func_t        func_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   result;

  // Handshakes: an issue transfers on a clock edge where issue_valid and
  // issue_ready are both high and squash is low; a result transfers on an edge
  // where cdb_req and cdb_grant are both high, with value/tag held until then.
  assign issue_ready = (state == IDLE);
  assign fire        = issue_valid & issue_ready & ~squash;
  assign cdb_req     = (state == WB);
  assign debug_state = state;

  // A done seen while start is still being presented belongs to the previous op.
  assign complete = mult_done & ~start_q;
  assign result   = (func_q == MUL) ? product[XLEN-1:0] : product[MULT_W-1:XLEN];

  always_comb begin
    state_nxt   = state;
    take_result = 1'b0;
    case (state)
      IDLE: begin
        if (fire) state_nxt = BUSY;
      end
      BUSY: begin
        if (squash) begin
          state_nxt = complete ? IDLE : DRAIN;
        end else if (complete) begin
          state_nxt   = WB;
          take_result = 1'b1;
        end
      end
      DRAIN: begin
        if (complete) state_nxt = IDLE;
      end
      WB: begin
        if (squash || cdb_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= fire;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      func_q   <= MUL;
      tag_q    <= '0;
    end else if (fire) begin
      mcand_q  <= extend(issue_rs1, (issue_func == MULH) || (issue_func == MULHSU));
      mplier_q <= extend(issue_rs2, (issue_func == MULH));
      func_q   <= mult_func_t'(issue_func);
      tag_q    <= issue_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_value <= '0;
      cdb_tag   <= '0;
    end else if (take_result) begin
      cdb_value <= result;
      cdb_tag   <= tag_q;
    end
  end

  mult u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (start_q),
    .mcand   (mcand_q),
    .mplier  (mplier_q),
    .product (product),
    .done    (mult_done)
  );

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
RV32M multiply functional unit wrapper. It sits between the multiply reservation-station issue port and the existing 64-bit `mult` core.
- Accepts one issued instruction at a time.
- Extends the 32-bit operands to 64 bits per funct, drives `mult`, and selects the upper or lower product half.
- Holds the result on the CDB request interface until granted.
- Supports squash at any point.

Parameters:
XLEN, 32, architectural operand/result width
TAG_W, 5, ROB tag width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  RS presents an instruction
issue_ready  out  1  unit can accept (state IDLE)
issue_rs1  in  XLEN  operand 1
issue_rs2  in  XLEN  operand 2
issue_func  in  2  MULT_FUNC: MUL=0, MULH=1, MULHSU=2, MULHU=3
issue_tag  in  TAG_W  destination ROB tag
squash  in  1  branch-mispredict flush; kills any in-flight op
cdb_req  out  1  result valid, requesting CDB
cdb_value  out  XLEN  result
cdb_tag  out  TAG_W  result tag
cdb_grant  in  1  CDB accepts result this cycle

Behaviour:
- Reset (async): state=IDLE, all registers 0; cdb_req=0, cdb_value=0, cdb_tag=0; mult start=0. `reset` also drives mult's reset.
- issue_ready = (state==IDLE). Fire = issue_valid & issue_ready & ~squash.
- Operand extension, registered at fire:
  - mcand = sign-extend rs1 for MULH/MULHSU, else zero-extend.
  - mplier = sign-extend rs2 for MULH, else zero-extend.
  - Also register func and tag.
- FSM states: IDLE, BUSY, DRAIN, WB.
- IDLE: on fire -> BUSY; start_q=1 for exactly the first BUSY cycle. mult operands come from registers only.
- BUSY:
  - A completion is mult done sampled high at a clock edge with start_q==0. done while start_q==1 is ignored (stale).
  - On completion: result = MUL ? product[31:0] : product[63:32]; latch into cdb_value and cdb_tag, then -> WB.
  - On squash without completion -> DRAIN.
  - On squash with completion in the same cycle -> IDLE; result discarded.
- DRAIN: wait for completion (same rule as BUSY), then -> IDLE. cdb_req stays 0. Squash here has no further effect.
- WB:
  - cdb_req=1; cdb_value and cdb_tag are held stable until grant.
  - On cdb_grant -> IDLE.
  - On squash -> IDLE; squash has priority over a simultaneous grant.
  - No same-cycle reissue: issue_ready rises the cycle after the grant.
- Latency: fire at edge N; start sampled at edge N+1. With L = mult cycles from start-sample to done, cdb_req rises L+1 cycles after N+1.
- Squash in IDLE: blocks a same-cycle issue.
- Reset mid-operation: immediate return to IDLE; mult is reset too, so no stale done reaches the unit.
- Throughput: one op in flight; no pipelining across ops.

Decomposition:
- Shared package (sys_defs): MULT_FUNC enum, XLEN, ROB tag width.
- Local FSM state enum lives in the module.
- One sub-module: the existing `mult`, instantiated unmodified.
- The extension/selection logic is small and stays inline.

Test Plan:
1. MUL rs1=7, rs2=FFFFFFFD, tag=3 -> cdb_req with cdb_value=FFFFFFEB, cdb_tag=3; issue_ready=0 from fire until the cycle after grant.
2. Funct matrix, rs1=rs2=FFFFFFFF:
   - MULH -> 00000000
   - MULHU -> FFFFFFFE
   - MULHSU -> FFFFFFFF
   - MUL -> 00000001
   - Then MULH 80000000*80000000 -> 40000000.
3. Backpressure: hold cdb_grant=0 for 5 cycles in WB -> cdb_req, value and tag stable; grant -> IDLE next cycle; back-to-back issue succeeds.
4. Squash two cycles after fire -> cdb_req never asserts; issue_ready returns to 1 only after mult done. A following MUL 6*9 yields 00000036.
5. Squash coincident with cdb_grant in WB, and squash coincident with issue_valid in IDLE -> no acceptance, no further cdb_req; unit IDLE next cycle.
6. Assert reset mid-BUSY -> all outputs 0 immediately. After release, MULHU 0001_0000*0001_0000 -> 00000001.
